// File: rtl/uart_pkg.sv
// Shared constants for the UART loopback slice: default bit timing,
// transmitter/receiver state encodings and seven-segment digit patterns
// (active-low, bit order {g,f,e,d,c,b,a}).
package uart_pkg;

    // clk cycles per serial bit; 1 means clk is the bit clock
    localparam int unsigned CLKS_PER_BIT_DEF = 1;

    // Transmitter states
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Digit patterns, active-low gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to seven-segment pattern.
//   digit : 4-bit value, 0-9 decoded, 10-15 blank
//   seg   : active-low {g,f,e,d,c,b,a}
module seg7_digit
    import uart_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/uart_loopback.sv
// 8N1 UART transmitter looped back into a receiver. A falling edge on the
// (synchronized) send button transmits `data`; the receiver decodes the
// looped-back line and shows the low five bits of the last good byte as two
// decimal digits.
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   btn_n    : send button, active-low, asynchronous to clk
//   data     : byte to transmit
//   tx_line  : serial line, idle high (also feeds the receiver)
//   led_data : last correctly received byte
//   disp1    : tens digit of the code, active-low gfedcba
//   disp0    : units digit of the code, active-low gfedcba
module uart_loopback
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [7:0] data,
    output logic       tx_line,
    output logic [7:0] led_data,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);

    // ------------------------------------------------------------------
    // Button synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic btn_meta;
    logic btn_sync;
    logic btn_prev;
    logic send_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            btn_prev <= 1'b1;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // One request per press: only the 1->0 transition counts
    assign send_req = btn_prev & ~btn_sync;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]       tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt,   tx_cnt_nxt;
    logic [2:0]       tx_bit,   tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_line_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // Line level is computed for the state being entered so tx_line is a flop
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_line_nxt  = tx_line;

        case (tx_state)
            TX_IDLE: begin
                tx_line_nxt = 1'b1;
                if (send_req) begin
                    tx_shift_nxt = data;
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_START;
                    tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                    tx_line_nxt  = tx_shift[0];
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                        tx_line_nxt  = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_line_nxt  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                    tx_line_nxt  = 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_line_nxt  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver input synchronizer
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= tx_line;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]       rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt,   rx_cnt_nxt;
    logic [2:0]       rx_bit,   rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [7:0]       led_data_nxt;
    logic [4:0]       code,     code_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            led_data <= 8'h00;
            code     <= 5'd0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            led_data <= led_data_nxt;
            code     <= code_nxt;
        end
    end

    // rx_cnt counts clocks from the sample where the start edge was seen,
    // so the start recheck lands on HALF_CNT and every later sample lands
    // CLKS_PER_BIT clocks after the previous one (bit centers).
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        led_data_nxt = led_data;
        code_nxt     = code;

        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    // With a zero half-bit wait the detecting sample is already
                    // the start-bit center, so it doubles as the recheck.
                    if (HALF_BIT == 0) begin
                        rx_state_nxt = RX_DATA;
                    end else begin
                        rx_state_nxt = RX_START;
                        rx_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_CNT) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    if (rx_sync) begin
                        rx_state_nxt = RX_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_nxt = RX_DATA;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    // Framing error leaves the displayed byte untouched
                    if (rx_sync) begin
                        led_data_nxt = rx_shift;
                        code_nxt     = rx_shift[4:0];
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decimal display of the 5-bit code
    // ------------------------------------------------------------------
    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        tens  = 4'(code / 5'd10);
        units = 4'(code % 5'd10);
    end

    seg7_digit u_tens (
        .digit (tens),
        .seg   (disp1)
    );

    seg7_digit u_units (
        .digit (units),
        .seg   (disp0)
    );

endmodule

// File: tb/tb_uart_loopback.sv
// Directed bench for uart_loopback with the default one-clock bit time.
module tb_uart_loopback;

    logic       clk;
    logic       rst_n;
    logic       btn_n;
    logic [7:0] data;
    logic       tx_line;
    logic [7:0] led_data;
    logic [6:0] disp1;
    logic [6:0] disp0;

    int n_checks = 0;
    int n_errors = 0;
    int frames   = 0;
    int skip     = 0;

    uart_loopback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    (btn_n),
        .data     (data),
        .tx_line  (tx_line),
        .led_data (led_data),
        .disp1    (disp1),
        .disp0    (disp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count 8N1 frames seen on the line: a low while idle starts a frame,
    // the following nine bit times belong to it.
    always @(negedge clk) begin
        if (!rst_n) begin
            skip = 0;
        end else if (skip > 0) begin
            skip = skip - 1;
        end else if (!tx_line) begin
            frames = frames + 1;
            skip   = 9;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Press the button, capture the ten line bits, then check the receiver.
    task automatic press_frame(input string tag, input logic [7:0] b,
                               input logic [9:0] exp_frame, input logic [7:0] exp_led,
                               input logic [6:0] exp_d1, input logic [6:0] exp_d0);
        int         lat;
        logic [9:0] bits;
        data  = b;
        btn_n = 1'b0;
        lat   = 0;
        @(negedge clk);
        lat = 1;
        while (tx_line && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " start_latency_ok"}, 32'(lat <= 3), 32'd1);
        btn_n   = 1'b1;
        bits[0] = tx_line;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            bits[i] = tx_line;
        end
        chk({tag, " frame"}, 32'(bits), 32'(exp_frame));
        for (int k = 0; k < 5 && led_data !== exp_led; k++) @(negedge clk);
        chk({tag, " led_data"}, 32'(led_data), 32'(exp_led));
        chk({tag, " disp1"}, 32'(disp1), 32'(exp_d1));
        chk({tag, " disp0"}, 32'(disp0), 32'(exp_d0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0;
        btn_n = 1'b1;
        data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_line", 32'(tx_line), 32'd1);
        chk("rst led_data", 32'(led_data), 32'h00);
        chk("rst disp1", 32'(disp1), 32'h40);
        chk("rst disp0", 32'(disp0), 32'h40);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 20 = 0x14: line 0,0,0,1,0,1,0,0,0,1 (first bit in bits[0])
        press_frame("b20", 8'd20, 10'b1000101000, 8'h14, 7'h24, 7'h40);
        // 44 = 0x2C -> code 12
        press_frame("b44", 8'd44, 10'b1001011000, 8'h2C, 7'h79, 7'h24);
        // 66 = 0x42 -> code 2
        press_frame("b66", 8'd66, 10'b1010000100, 8'h42, 7'h40, 7'h24);

        // Second press and data change mid-frame are ignored: 0x5A -> code 26
        f0    = frames;
        data  = 8'h5A;
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        btn_n = 1'b1;
        data  = 8'hFF;
        repeat (2) @(negedge clk);
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midframe frames", 32'(frames - f0), 32'd1);
        chk("midframe led_data", 32'(led_data), 32'h5A);
        chk("midframe disp1", 32'(disp1), 32'h24);
        chk("midframe disp0", 32'(disp0), 32'h02);

        // Button held low for 100 clocks: one frame only. 0x33 -> code 19
        f0    = frames;
        data  = 8'h33;
        btn_n = 1'b0;
        repeat (100) @(negedge clk);
        btn_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold frames", 32'(frames - f0), 32'd1);
        chk("hold led_data", 32'(led_data), 32'h33);
        chk("hold disp1", 32'(disp1), 32'h79);
        chk("hold disp0", 32'(disp0), 32'h10);

        // Reset during the data bits
        data  = 8'hC3;
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        btn_n = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst tx_line", 32'(tx_line), 32'd1);
        chk("midrst led_data", 32'(led_data), 32'h00);
        chk("midrst disp1", 32'(disp1), 32'h40);
        chk("midrst disp0", 32'(disp0), 32'h40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst no_update", 32'(led_data), 32'h00);
        chk("postrst idle_line", 32'(tx_line), 32'd1);
        press_frame("postrst b20", 8'd20, 10'b1000101000, 8'h14, 7'h24, 7'h40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_loopback.md
UART_LOOPBACK -- requirements
Module: uart_loopback

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; with the default, clk is the bit clock (9600 Hz nominal).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_n  input  1  send button, active-low, asynchronous to clk.
REQ-005 data  input  8  byte to transmit.
REQ-006 tx_line  output  1  serial line, 8N1, idle high; also internally looped to the receiver.
REQ-007 led_data  output  8  last correctly received byte.
REQ-008 disp1  output  7  tens digit of the display code, active-low {g,f,e,d,c,b,a}.
REQ-009 disp0  output  7  units digit of the display code, same encoding.

Function
REQ-010 btn_n SHALL pass a 2-flop synchronizer; a send request is a synchronized 1->0 transition; holding btn_n low SHALL NOT retrigger.
REQ-011 Transmitter FSM states IDLE, START, DATA, STOP; IDLE drives tx_line=1.
REQ-012 On a send request in IDLE, data SHALL be latched and the FSM SHALL enter START on the next clock.
REQ-013 Frame: start bit 0, data[0]..data[7] LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT clocks; then return to IDLE.
REQ-014 Send requests while not IDLE SHALL be ignored (not queued); changes to data mid-frame SHALL NOT affect the frame in flight.
REQ-015 The receiver input SHALL be tx_line through a 2-flop synchronizer.
REQ-016 Receiver FSM states IDLE, START, DATA, STOP; IDLE leaves on a synchronized low level.
REQ-017 START SHALL wait CLKS_PER_BIT/2 clocks (integer division; 0 when CLKS_PER_BIT=1) and recheck low; if the line is high, return to IDLE (glitch).
REQ-018 DATA SHALL sample 8 bits, one per CLKS_PER_BIT clocks, at bit centers, shifted in LSB first.
REQ-019 STOP SHALL sample one bit; if 1, led_data <= byte and code <= byte[4:0] on the same edge; if 0 (framing error), discard the byte and hold the outputs.
REQ-020 Receiver SHALL return to IDLE after STOP and accept back-to-back frames.
REQ-021 Display SHALL be combinational from the 5-bit code (0-31): tens = code/10 (0-3), units = code%10.
REQ-022 Digit patterns (hex, active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
REQ-023 Latency, CLKS_PER_BIT=1: start bit on tx_line no later than 3 clocks after btn_n falls; led_data valid no later than 14 clocks after the start bit appears.

Reset
REQ-024 rst_n low SHALL asynchronously force both FSMs to IDLE, tx_line=1, led_data=0x00, code=0 (disp1=disp0=0x40), and all synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL abort the frame with no partial update of led_data/code; after release, the first send request SHALL produce a full frame.

Structure
REQ-026 Package uart_pkg SHALL hold the CLKS_PER_BIT default, the TX/RX state encodings and the ten digit constants.
REQ-027 Sub-module seg7_digit (4-bit digit in, 7-bit pattern out), instantiated twice; TX, RX and synchronizers stay in uart_loopback.

Verification
REQ-028 Reset asserted -> tx_line=1, led_data=0x00, disp1=0x40, disp0=0x40.
REQ-029 data=20, pulse btn_n low -> tx_line sequence 0,0,0,1,0,1,0,0,0,1; led_data=0x14, code=20, disp1=0x24, disp0=0x40.
REQ-030 data=44, press -> led_data=0x2C, code=12, disp1=0x79, disp0=0x24; data=66, press -> led_data=0x42, code=2, disp1=0x40, disp0=0x24.
REQ-031 Second press, and a data change, during a frame -> ignored; exactly one frame with the originally latched byte.
REQ-032 btn_n held low 100 clocks -> exactly one frame.
REQ-033 rst_n pulsed during DATA -> tx_line=1 at once, outputs reset; the next press (data=20) yields led_data=0x14.
